// File: rtl/instr_decode_stage.sv
// Decode stage between fetch and execute of the OLED controller core. It splits each instruction
// into control fields, forwards them over valid/ready, and runs I2C instructions as timed transactions.
module instr_decode_stage #(
  parameter  int DATA_W  = 8,
  parameter  int REG_AW  = 4,
  parameter  int I2C_TO  = 1024,
  localparam int INSTR_W = 5 + 2 * REG_AW + DATA_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2:0]         o_opcode,
  output logic [REG_AW-1:0]  o_dest,
  output logic [REG_AW-1:0]  o_src,
  output logic [DATA_W-1:0]  o_imm,
  output logic [DATA_W-1:0]  o_addr,
  output logic               o_rs_wen,
  output logic               o_flg_wen,
  output logic               o_mem_rd,
  output logic               o_sendcon,
  output logic               o_i2c_req,
  output logic [1:0]         o_i2c_cmd,
  output logic [DATA_W-1:0]  o_i2c_data,
  input  logic               i_i2c_done,
  output logic               o_i2c_err,
  output logic               o_illegal
);

  localparam int CNT_W = (I2C_TO > 2) ? $clog2(I2C_TO) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(I2C_TO - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_I2C_WAIT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [2:0]          opcode_q, opcode_d;
  logic [REG_AW-1:0]   dest_q, dest_d, src_q, src_d;
  logic [DATA_W-1:0]   imm_q, imm_d, addr_q, addr_d;
  logic                rs_wen_q, rs_wen_d, flg_wen_q, flg_wen_d;
  logic                mem_rd_q, mem_rd_d, sendcon_q, sendcon_d;
  logic                req_q, req_d, err_q, err_d, illegal_q, illegal_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [4:0]          op_s;
  logic [REG_AW-1:0]   dest_s, src_s;
  logic [DATA_W-1:0]   imm_s;
  logic [2:0]          dec_alu_s;
  logic                dec_rs_s, dec_flg_s, dec_mem_s, dec_con_s;
  logic                dec_i2c_s, dec_ill_s;
  logic [1:0]          dec_cmd_s;
  logic                ready_s, accept_s;

  assign op_s   = i_instr[INSTR_W-1 -: 5];
  assign dest_s = i_instr[INSTR_W-6 -: REG_AW];
  assign src_s  = i_instr[DATA_W+REG_AW-1 -: REG_AW];
  assign imm_s  = i_instr[DATA_W-1:0];

  // Opcode decode into control fields; anything unlisted decodes as an illegal NOP.
  always_comb begin
    dec_alu_s = 3'b000;
    dec_rs_s  = 1'b0;
    dec_flg_s = 1'b0;
    dec_mem_s = 1'b0;
    dec_con_s = 1'b0;
    dec_i2c_s = 1'b0;
    dec_ill_s = 1'b0;
    dec_cmd_s = 2'b00;
    case (op_s)
      5'b00000: begin dec_alu_s = 3'b001; dec_rs_s = 1'b1; dec_flg_s = 1'b1; end
      5'b00010: begin dec_alu_s = 3'b010; dec_rs_s = 1'b1; dec_flg_s = 1'b1; end
      5'b00101: begin dec_alu_s = 3'b001; dec_rs_s = 1'b1; dec_flg_s = 1'b1; end
      5'b01010: begin dec_rs_s = 1'b1; dec_mem_s = 1'b1; end
      5'b01100: dec_con_s = 1'b1;
      5'b10011: dec_alu_s = 3'b011;
      5'b10101: dec_alu_s = 3'b100;
      5'b00110: begin dec_i2c_s = 1'b1; dec_cmd_s = 2'b00; end
      5'b01000: begin dec_i2c_s = 1'b1; dec_cmd_s = 2'b01; end
      5'b01110: begin dec_i2c_s = 1'b1; dec_cmd_s = 2'b10; end
      5'b11111: dec_alu_s = 3'b000;
      default:  dec_ill_s = 1'b1;
    endcase
  end

  assign ready_s  = (state_q == S_IDLE) && (!valid_q || i_ready) && !i_flush;
  assign accept_s = i_valid && ready_s;

  // Next-state logic for the output bundle, the I2C transaction FSM and the sticky illegal flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    dest_d    = dest_q;
    src_d     = src_q;
    imm_d     = imm_q;
    addr_d    = addr_q;
    rs_wen_d  = rs_wen_q;
    flg_wen_d = flg_wen_q;
    mem_rd_d  = mem_rd_q;
    sendcon_d = sendcon_q;
    req_d     = req_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    err_d     = 1'b0;
    illegal_d = illegal_q;

    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept_s && !dec_i2c_s) begin
      valid_d   = 1'b1;
      opcode_d  = dec_alu_s;
      dest_d    = dest_s;
      src_d     = src_s;
      imm_d     = imm_s;
      addr_d    = dec_mem_s ? imm_s : '0;
      rs_wen_d  = dec_rs_s;
      flg_wen_d = dec_flg_s;
      mem_rd_d  = dec_mem_s;
      sendcon_d = dec_con_s;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (accept_s && dec_ill_s) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end

    case (state_q)
      S_IDLE: begin
        if (accept_s && dec_i2c_s) begin
          state_d = S_I2C_WAIT;
          req_d   = 1'b1;
          cmd_d   = dec_cmd_s;
          data_d  = (dec_cmd_s == 2'b10) ? imm_s : '0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_I2C_WAIT: begin
        // A done in the timeout cycle takes priority, so no error is raised then.
        if (i_i2c_done) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset to all-zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      opcode_q  <= 3'b000;
      dest_q    <= '0;
      src_q     <= '0;
      imm_q     <= '0;
      addr_q    <= '0;
      rs_wen_q  <= 1'b0;
      flg_wen_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      sendcon_q <= 1'b0;
      req_q     <= 1'b0;
      cmd_q     <= 2'b00;
      data_q    <= '0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      dest_q    <= dest_d;
      src_q     <= src_d;
      imm_q     <= imm_d;
      addr_q    <= addr_d;
      rs_wen_q  <= rs_wen_d;
      flg_wen_q <= flg_wen_d;
      mem_rd_q  <= mem_rd_d;
      sendcon_q <= sendcon_d;
      req_q     <= req_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_ready    = ready_s;
  assign o_valid    = valid_q;
  assign o_opcode   = opcode_q;
  assign o_dest     = dest_q;
  assign o_src      = src_q;
  assign o_imm      = imm_q;
  assign o_addr     = addr_q;
  assign o_rs_wen   = rs_wen_q;
  assign o_flg_wen  = flg_wen_q;
  assign o_mem_rd   = mem_rd_q;
  assign o_sendcon  = sendcon_q;
  assign o_i2c_req  = req_q;
  assign o_i2c_cmd  = cmd_q;
  assign o_i2c_data = data_q;
  assign o_i2c_err  = err_q;
  assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage with I2C_TO=16 and hand-computed expectations.
module tb_instr_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [20:0] instr;
  logic        in_valid, out_ready, flush, out_valid, ex_ready;
  logic [2:0]  opcode;
  logic [3:0]  dest, src;
  logic [7:0]  imm, addr, i2c_data;
  logic        rs_wen, flg_wen, mem_rd, sendcon, i2c_req, i2c_done, i2c_err, illegal;
  logic [1:0]  i2c_cmd;

  int errors = 0;
  int checks = 0;

  instr_decode_stage #(.DATA_W(8), .REG_AW(4), .I2C_TO(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_valid(in_valid), .o_ready(out_ready),
    .i_flush(flush), .o_valid(out_valid), .i_ready(ex_ready), .o_opcode(opcode),
    .o_dest(dest), .o_src(src), .o_imm(imm), .o_addr(addr), .o_rs_wen(rs_wen),
    .o_flg_wen(flg_wen), .o_mem_rd(mem_rd), .o_sendcon(sendcon), .o_i2c_req(i2c_req),
    .o_i2c_cmd(i2c_cmd), .o_i2c_data(i2c_data), .i_i2c_done(i2c_done),
    .o_i2c_err(i2c_err), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] mk(input logic [4:0] op, input logic [3:0] d,
                                     input logic [3:0] s, input logic [7:0] im);
    return {op, d, s, im};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr = 21'd0; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0; i2c_done = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req", {31'd0, i2c_req}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_opcode", {29'd0, opcode}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // ADDI dest=3 src=0 imm=0x5A
    instr = mk(5'b00101, 4'd3, 4'd0, 8'h5A); in_valid = 1'b1; ex_ready = 1'b1;
    #1 chk("addi_ready", {31'd0, out_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_op", {29'd0, opcode}, 32'd1);
    chk("addi_dest", {28'd0, dest}, 32'd3);
    chk("addi_imm", {24'd0, imm}, 32'h5A);
    chk("addi_en", {28'd0, rs_wen, flg_wen, mem_rd, sendcon}, 32'b1100);
    chk("addi_addr", {24'd0, addr}, 32'd0);
    tick();
    chk("addi_taken", {31'd0, out_valid}, 32'd0);

    // ADD then SUB stalled by execute for three cycles
    ex_ready = 1'b0;
    instr = mk(5'b00000, 4'd1, 4'd2, 8'h00); in_valid = 1'b1;
    tick();
    instr = mk(5'b00010, 4'd4, 4'd5, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", {31'd0, out_ready}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_op", {29'd0, opcode}, 32'd1);
      chk("stall_dest", {28'd0, dest}, 32'd1);
      tick();
    end
    ex_ready = 1'b1;
    #1 chk("unstall_ready", {31'd0, out_ready}, 32'd1);
    tick();
    chk("sub_op", {29'd0, opcode}, 32'd2);
    chk("sub_dest", {28'd0, dest}, 32'd4);
    instr = mk(5'b01010, 4'd6, 4'd0, 8'h10);
    tick(); in_valid = 1'b0;
    chk("load_valid", {31'd0, out_valid}, 32'd1);
    chk("load_op", {29'd0, opcode}, 32'd0);
    chk("load_addr", {24'd0, addr}, 32'h10);
    chk("load_en", {28'd0, rs_wen, flg_wen, mem_rd, sendcon}, 32'b1010);
    tick();
    chk("load_taken", {31'd0, out_valid}, 32'd0);

    // SENDI2C 0xAE, done during the fifth request cycle
    instr = mk(5'b01110, 4'd0, 4'd0, 8'hAE); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("i2c_cmd", {30'd0, i2c_cmd}, 32'd2);
    chk("i2c_data", {24'd0, i2c_data}, 32'hAE);
    for (int i = 1; i <= 5; i++) begin
      chk("i2c_req", {31'd0, i2c_req}, 32'd1);
      chk("i2c_busy", {31'd0, out_ready}, 32'd0);
      chk("i2c_novalid", {31'd0, out_valid}, 32'd0);
      if (i == 5) i2c_done = 1'b1;
      tick();
      i2c_done = 1'b0;
    end
    #1;
    chk("i2c_req_drop", {31'd0, i2c_req}, 32'd0);
    chk("i2c_no_err", {31'd0, i2c_err}, 32'd0);
    chk("i2c_idle_ready", {31'd0, out_ready}, 32'd1);

    // I2CSTART without done: timeout after 16 cycles
    instr = mk(5'b00110, 4'd0, 4'd0, 8'h00); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("start_cmd", {30'd0, i2c_cmd}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      chk("to_req", {31'd0, i2c_req}, 32'd1);
      chk("to_err_low", {31'd0, i2c_err}, 32'd0);
      tick();
    end
    chk("to_req_drop", {31'd0, i2c_req}, 32'd0);
    chk("to_err", {31'd0, i2c_err}, 32'd1);
    instr = mk(5'b11111, 4'd2, 4'd3, 8'h44); in_valid = 1'b1;
    #1 chk("to_ready", {31'd0, out_ready}, 32'd1);
    tick();
    chk("to_err_pulse", {31'd0, i2c_err}, 32'd0);
    chk("nop_valid", {31'd0, out_valid}, 32'd1);
    chk("nop_en", {28'd0, rs_wen, flg_wen, mem_rd, sendcon}, 32'd0);

    // Illegal opcode 00001, then flush the held bundle
    instr = mk(5'b00001, 4'd7, 4'd7, 8'hFF);
    tick(); in_valid = 1'b0; ex_ready = 1'b0;
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_op", {29'd0, opcode}, 32'd0);
    chk("ill_en", {28'd0, rs_wen, flg_wen, mem_rd, sendcon}, 32'd0);
    tick();
    chk("ill_held", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    #1 chk("flush_ready", {31'd0, out_ready}, 32'd0);
    tick(); flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("ill_sticky", {31'd0, illegal}, 32'd1);

    // Asynchronous reset in the middle of an I2C wait
    ex_ready = 1'b1;
    instr = mk(5'b01000, 4'd0, 4'd0, 8'h00); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("stop_req", {31'd0, i2c_req}, 32'd1);
    chk("stop_cmd", {30'd0, i2c_cmd}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, i2c_req}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_illegal", {31'd0, illegal}, 32'd0);
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
